// File: rtl/ahbl_sram_bridge.sv
// ahbl_sram_bridge
// ----------------------------------------------------------------------------
// Zero-wait-state AHB-Lite slave in front of a byte-enabled synchronous
// single-port SRAM. The SRAM has a 1-cycle read latency and a registered
// write.
//
// Reads use the SRAM port during their address phase. Write data arrives a
// cycle later, in the data phase. It is parked in a one-entry write buffer
// and written to the SRAM in the next cycle where no read address phase
// claims the port. Reads are compared against the buffer and the matching
// byte lanes are taken from it, so a read that follows a write returns the
// new data.
//
// Ports
//   clk, rst_n           system clock, synchronous active-low reset
//   ahbls_hready         bus-wide HREADY
//   ahbls_hready_resp    slave HREADYOUT (low only in the first error cycle)
//   ahbls_hresp          slave HRESP
//   ahbls_haddr/hwrite/htrans/hsize/hwdata   AHB-Lite request and write data
//   ahbls_hburst/hprot/hmastlock             accepted but not used
//   ahbls_hrdata         read data, zero outside a read data phase
//   sram_addr/wen/wdata  SRAM word address, per-byte write enable, write data
//   sram_rdata           SRAM read data, valid the cycle after sram_addr
//
// States
//   S_IDLE  | no data phase in progress
//   S_RDATA | read data phase, hrdata = forwarded SRAM data
//   S_WDATA | write data phase, hwdata is captured into the buffer
//   S_ERR1  | first error cycle (hready_resp=0, hresp=1)
//   S_ERR2  | second error cycle (hready_resp=1, hresp=1)
// ----------------------------------------------------------------------------
module ahbl_sram_bridge #(
  parameter int W_DATA      = 32,
  parameter int W_ADDR      = 32,
  parameter int DEPTH       = 2048,
  parameter int W_SRAM_ADDR = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   ahbls_hready,
  output logic                   ahbls_hready_resp,
  output logic                   ahbls_hresp,
  input  logic [W_ADDR-1:0]      ahbls_haddr,
  input  logic                   ahbls_hwrite,
  input  logic [1:0]             ahbls_htrans,
  input  logic [2:0]             ahbls_hsize,
  input  logic [2:0]             ahbls_hburst,
  input  logic [3:0]             ahbls_hprot,
  input  logic                   ahbls_hmastlock,
  input  logic [W_DATA-1:0]      ahbls_hwdata,
  output logic [W_DATA-1:0]      ahbls_hrdata,

  output logic [W_SRAM_ADDR-1:0] sram_addr,
  output logic [W_DATA/8-1:0]    sram_wen,
  output logic [W_DATA-1:0]      sram_wdata,
  input  logic [W_DATA-1:0]      sram_rdata
);

  localparam int NB = W_DATA / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDATA,
    S_WDATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                 state_q, state_d;
  logic [W_SRAM_ADDR-1:0] addr_q, addr_d;
  logic [NB-1:0]          mask_q, mask_d;

  logic                   buf_valid_q, buf_valid_d;
  logic [W_SRAM_ADDR-1:0] buf_addr_q, buf_addr_d;
  logic [NB-1:0]          buf_mask_q, buf_mask_d;
  logic [W_DATA-1:0]      buf_data_q, buf_data_d;

  logic                   aph_valid;
  logic                   size_ok;
  logic                   rd_aph;
  logic [W_SRAM_ADDR-1:0] aph_idx;
  logic [NB-1:0]          aph_mask;
  logic                   fwd_hit;

  // Bus fields this slave has no use for; the upper address bits are dropped
  // on purpose so the SRAM aliases across the whole address space.
  logic unused_inputs;
  assign unused_inputs = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                           ahbls_htrans[0],
                           ahbls_haddr[W_ADDR-1:LB+W_SRAM_ADDR]};

  // --------------------------------------------------------------------------
  // Address phase decode
  // --------------------------------------------------------------------------
  // No new transfer is taken while this slave holds the bus in ERR1. The bus
  // HREADY is low then anyway, so this only guards against a fabric that
  // does not feed HREADYOUT back.
  assign aph_valid = ahbls_hready && ahbls_htrans[1] && (state_q != S_ERR1);
  assign size_ok   = (ahbls_hsize <= 3'(LB));
  assign rd_aph    = aph_valid && size_ok && !ahbls_hwrite;
  assign aph_idx   = ahbls_haddr[LB +: W_SRAM_ADDR];

  // A lane belongs to the transfer when it falls in the same 2^hsize-aligned
  // group as the byte offset. This rounds unaligned offsets down to the size.
  always_comb begin
    aph_mask = '0;
    for (int i = 0; i < NB; i++) begin
      if ((i >> ahbls_hsize) == (int'(ahbls_haddr[LB-1:0]) >> ahbls_hsize)) begin
        aph_mask[i] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Data phase state machine
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if (ahbls_hready) begin
      if (!aph_valid) begin
        state_d = S_IDLE;
      end else if (!size_ok) begin
        state_d = S_ERR1;
      end else begin
        state_d = ahbls_hwrite ? S_WDATA : S_RDATA;
        addr_d  = aph_idx;
        mask_d  = aph_mask;
      end
    end
  end

  always_comb begin
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = 1'b0;
    if (rst_n) begin
      ahbls_hready_resp = (state_q != S_ERR1);
      ahbls_hresp       = (state_q == S_ERR1) || (state_q == S_ERR2);
    end
  end

  // --------------------------------------------------------------------------
  // SRAM port arbitration and write buffer
  // --------------------------------------------------------------------------
  always_comb begin
    sram_addr   = buf_addr_q;
    sram_wdata  = buf_data_q;
    sram_wen    = '0;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_mask_d  = buf_mask_q;
    buf_data_d  = buf_data_q;

    if (rd_aph) begin
      sram_addr = aph_idx;
    end else if (buf_valid_q) begin
      sram_wen    = buf_mask_q;
      buf_valid_d = 1'b0;
    end

    // Loading after the drain above lets a same-cycle drain/load keep the
    // new entry.
    if (state_q == S_WDATA) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = addr_q;
      buf_mask_d  = mask_q;
      buf_data_d  = ahbls_hwdata;
    end

    // The SRAM samples wen on the same edge that clears the buffer, so the
    // pending write must be suppressed during reset to be truly discarded.
    if (!rst_n) begin
      sram_wen = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Read data with byte-lane forwarding from the write buffer
  // --------------------------------------------------------------------------
  assign fwd_hit = buf_valid_q && (buf_addr_q == addr_q);

  always_comb begin
    ahbls_hrdata = '0;
    if (rst_n && (state_q == S_RDATA)) begin
      for (int i = 0; i < NB; i++) begin
        if (fwd_hit && buf_mask_q[i]) begin
          ahbls_hrdata[8*i +: 8] = buf_data_q[8*i +: 8];
        end else begin
          ahbls_hrdata[8*i +: 8] = sram_rdata[8*i +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      mask_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_mask_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_mask_q  <= buf_mask_d;
      buf_data_q  <= buf_data_d;
    end
  end

  // A load must never replace an entry that has not reached the SRAM: when a
  // write data phase finds the buffer occupied, the port has to be draining
  // it in that same cycle. A write, write, read address sequence would
  // break this, because the read claims the port in the cycle the first
  // write would drain.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state_q == S_WDATA && buf_valid_q) |-> !rd_aph);

endmodule

// File: tb/tb_ahbl_sram_bridge.sv
module tb_ahbl_sram_bridge;

  localparam int W_DATA = 32;
  localparam int W_ADDR = 32;
  localparam int DEPTH  = 2048;
  localparam int W_SA   = 11;
  localparam int NB     = 4;

  localparam int K_NONE = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;
  localparam int K_ILL  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              hready;
  logic              hready_resp;
  logic              hresp;
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic [W_DATA-1:0] hwdata;
  logic [W_DATA-1:0] hrdata;
  logic [W_SA-1:0]   sram_addr;
  logic [NB-1:0]     sram_wen;
  logic [W_DATA-1:0] sram_wdata;
  logic [W_DATA-1:0] sram_rdata;

  ahbl_sram_bridge #(
    .W_DATA(W_DATA),
    .W_ADDR(W_ADDR),
    .DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ahbls_hready     (hready),
    .ahbls_hready_resp(hready_resp),
    .ahbls_hresp      (hresp),
    .ahbls_haddr      (haddr),
    .ahbls_hwrite     (hwrite),
    .ahbls_htrans     (htrans),
    .ahbls_hsize      (hsize),
    .ahbls_hburst     (hburst),
    .ahbls_hprot      (hprot),
    .ahbls_hmastlock  (hmastlock),
    .ahbls_hwdata     (hwdata),
    .ahbls_hrdata     (hrdata),
    .sram_addr        (sram_addr),
    .sram_wen         (sram_wen),
    .sram_wdata       (sram_wdata),
    .sram_rdata       (sram_rdata)
  );

  // Single slave on the bus: HREADY is this slave's own HREADYOUT.
  assign hready = hready_resp;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hA5C3_0F1E;
  endfunction

  // Behavioural SRAM: byte-enabled write, registered read.
  logic [31:0] mem [DEPTH];
  bit          mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else begin
      for (int l = 0; l < NB; l++) begin
        if (sram_wen[l]) mem[sram_addr][8*l +: 8] <= sram_wdata[8*l +: 8];
      end
    end
    sram_rdata <= mem[sram_addr];
  end

  // Reference: the bus should look like a plain coherent byte memory.
  logic [31:0] ref_mem [DEPTH];

  int n_pass = 0;
  int n_fail = 0;

  int          dp_kind = K_NONE;
  logic [31:0] dp_addr = '0;
  logic [2:0]  dp_size = '0;
  logic [31:0] dp_wdata = '0;
  bit          err2_pending = 1'b0;

  logic [NB-1:0] snap_wen;
  logic [W_SA-1:0] snap_addr;
  logic [31:0]   snap_wdata;
  logic [31:0]   snap_rdata;

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wd);
    int nbytes;
    int base;
    int idx;
    nbytes = 1 << size;
    base   = (int'(addr % 4) / nbytes) * nbytes;
    idx    = word_of(addr);
    for (int b = base; b < base + nbytes; b++) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: present an address phase (kind) plus the write data of the
  // previous transfer, check the previous transfer's data phase at negedge.
  task automatic step(input int kind, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wd);
    bit   was_reset;
    logic exp_ready;
    logic exp_resp;
    htrans    = (kind == K_NONE) ? 2'($urandom_range(0, 1)) : 2'b10;
    hwrite    = (kind == K_WR) || (kind == K_ILL && $urandom_range(0, 1) == 1);
    haddr     = addr;
    hsize     = size;
    hburst    = 3'($urandom);
    hprot     = 4'($urandom);
    hmastlock = 1'($urandom);
    hwdata    = dp_wdata;
    @(negedge clk);
    was_reset  = !rst_n;
    snap_wen   = sram_wen;
    snap_addr  = sram_addr;
    snap_wdata = sram_wdata;
    snap_rdata = hrdata;
    if (was_reset) begin
      check("rst_hready_resp", 32'(hready_resp), 32'd1);
      check("rst_hresp", 32'(hresp), 32'd0);
      check("rst_hrdata", hrdata, 32'd0);
      check("rst_sram_wen", 32'(sram_wen), 32'd0);
      err2_pending = 1'b0;
    end else begin
      exp_ready = 1'b1;
      exp_resp  = 1'b0;
      if (dp_kind == K_ILL) begin
        exp_ready = 1'b0;
        exp_resp  = 1'b1;
      end else if (err2_pending) begin
        exp_resp = 1'b1;
      end
      check("hready_resp", 32'(hready_resp), 32'(exp_ready));
      check("hresp", 32'(hresp), 32'(exp_resp));
      if (dp_kind == K_RD) check("hrdata_read", hrdata, ref_mem[word_of(dp_addr)]);
      else check("hrdata_not_read", hrdata, 32'd0);
      if (dp_kind == K_WR) ref_write(dp_addr, dp_size, hwdata);
      err2_pending = (dp_kind == K_ILL);
    end
    @(posedge clk);
    #1;
    dp_kind  = was_reset ? K_NONE : kind;
    dp_addr  = addr;
    dp_size  = size;
    dp_wdata = wd;
  endtask

  task automatic idle();
    step(K_NONE, 32'h0, 3'd0, 32'h0);
  endtask

  initial begin
    logic [31:0] saved;
    int          kind;
    int          pk1;
    int          pk2;
    int          r;
    logic [2:0]  size;
    logic [31:0] addr;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    idle();
    idle();
    idle();
    rst_n = 1'b1;
    idle();

    // Single word write, drained one cycle after its data phase.
    step(K_WR, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF);
    idle();
    check("t1_wen_in_dphase", 32'(snap_wen), 32'h0);
    idle();
    check("t1_wen", 32'(snap_wen), 32'hF);
    check("t1_addr", 32'(snap_addr), 32'd4);
    check("t1_wdata", snap_wdata, 32'hDEAD_BEEF);
    idle();
    check("t1_wen_after", 32'(snap_wen), 32'h0);

    // Write then read of the same word: forwarded, drained in the read's data phase.
    step(K_WR, 32'h20, 3'd2, 32'h1122_3344);
    step(K_RD, 32'h20, 3'd2, 32'h0);
    check("t2_wen_rd_aphase", 32'(snap_wen), 32'h0);
    idle();
    check("t2_fwd_rdata", snap_rdata, 32'h1122_3344);
    check("t2_wen", 32'(snap_wen), 32'hF);
    check("t2_addr", 32'(snap_addr), 32'd8);

    // Byte write merged into an existing word; other hwdata lanes are ignored.
    step(K_WR, 32'h30, 3'd2, 32'h0102_0304);
    idle();
    idle();
    step(K_WR, 32'h31, 3'd0, 32'h7700_AB66);
    step(K_RD, 32'h30, 3'd2, 32'h0);
    idle();
    check("t3_rdata", snap_rdata, 32'h0102_AB04);
    check("t3_wen", 32'(snap_wen), 32'h2);
    check("t3_addr", 32'(snap_addr), 32'd12);
    check("t3_wdata_lane1", 32'(snap_wdata[15:8]), 32'hAB);

    // Halfword write followed by an alternating pipelined stream.
    step(K_WR, 32'h42, 3'd1, 32'hCAFE_1234);
    step(K_RD, 32'h40, 3'd2, 32'h0);
    step(K_WR, 32'h70, 3'd2, 32'h1357_9BDF);
    check("t4_half_rdata", 32'(snap_rdata[31:16]), 32'hCAFE);
    step(K_RD, 32'h80, 3'd2, 32'h0);
    step(K_WR, 32'h91, 3'd0, 32'h0000_5A00);
    step(K_RD, 32'h70, 3'd2, 32'h0);
    idle();
    check("t4_rdata_70", snap_rdata, 32'h1357_9BDF);
    idle();

    // Illegal size: two-cycle error response, pending write drains in ERR1.
    step(K_WR, 32'h58, 3'd2, 32'h0BAD_F00D);
    step(K_ILL, 32'h50, 3'd3, 32'h0);
    check("t5_wen_ill_aphase", 32'(snap_wen), 32'h0);
    idle();
    check("t5_wen_err1", 32'(snap_wen), 32'hF);
    check("t5_addr_err1", 32'(snap_addr), 32'd22);
    idle();
    check("t5_wen_err2", 32'(snap_wen), 32'h0);
    idle();

    // Reset while a write sits in the buffer: the write is lost.
    saved = ref_mem[24];
    step(K_WR, 32'h60, 3'd2, 32'h55AA_55AA);
    idle();
    rst_n = 1'b0;
    idle();
    check("t6_wen_in_reset", 32'(snap_wen), 32'h0);
    rst_n = 1'b1;
    ref_mem[24] = saved;
    idle();
    check("t6_wen_after_reset", 32'(snap_wen), 32'h0);
    step(K_RD, 32'h60, 3'd2, 32'h0);
    idle();
    check("t6_rdata", snap_rdata, init_word(24));

    // Random traffic with aliased high address bits. Two back-to-back write
    // address phases are never followed directly by a read address phase.
    pk1 = K_NONE;
    pk2 = K_NONE;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20)      kind = K_NONE;
      else if (r < 58) kind = K_WR;
      else if (r < 95) kind = K_RD;
      else             kind = K_ILL;
      if (pk1 == K_ILL) kind = K_NONE;
      if (kind == K_RD && pk1 == K_WR && pk2 == K_WR) kind = K_NONE;
      size = (kind == K_ILL) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      addr = ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
      step(kind, addr, size, $urandom);
      pk2 = pk1;
      pk1 = kind;
    end
    idle();
    idle();
    idle();

    for (int i = 0; i < DEPTH; i++) check("mem_image", mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
